// File: rtl/pulser_pkg.sv
// Shared definitions for the edge pulser: edge-select encodings and counter sizing.
package pulser_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    // Bits needed to hold a stretch count of 0..len.
    function automatic int unsigned cnt_width(input int unsigned len);
        return (len < 1) ? 1 : $clog2(len + 1);
    endfunction

endpackage

// File: rtl/edge_pulser_ch.sv
// One edge-detect channel: edge select, pulse stretcher and sticky event/overflow flags.
module edge_pulser_ch
    import pulser_pkg::*;
#(
    parameter int unsigned PULSE_LEN = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in,
    input  logic [MODE_W-1:0] i_mode,
    input  logic              i_clear,
    input  logic              i_ack,
    output logic              pulse_c,
    output logic              evt_q,
    output logic              ovf_q
);

    localparam int unsigned   CW   = cnt_width(PULSE_LEN);
    localparam logic [CW-1:0] LOAD = CW'(PULSE_LEN - 1);

    logic          prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          edge_c;
    logic          evt_d;
    logic          ovf_d;
    mode_e         mode;

    assign mode = mode_e'(i_mode);

    // Mode-selected edge; clear suppresses it outright.
    always_comb begin
        edge_c = 1'b0;
        case (mode)
            MODE_RISE: edge_c = i_in & ~prev_q;
            MODE_FALL: edge_c = ~i_in & prev_q;
            MODE_BOTH: edge_c = i_in ^ prev_q;
            default:   edge_c = 1'b0;
        endcase
        if (i_clear) begin
            edge_c = 1'b0;
        end
    end

    // Stretch counter: a fresh edge restarts the full length, otherwise count down to 0.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (edge_c) begin
            cnt_d = LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Sticky flags: clear beats everything, a new edge beats an acknowledge.
    always_comb begin
        evt_d = evt_q;
        ovf_d = ovf_q;
        if (i_clear) begin
            evt_d = 1'b0;
            ovf_d = 1'b0;
        end else begin
            if (edge_c) begin
                evt_d = 1'b1;
            end else if (i_ack) begin
                evt_d = 1'b0;
            end
            if (edge_c && evt_q && !i_ack) begin
                ovf_d = 1'b1;
            end else if (i_ack) begin
                ovf_d = 1'b0;
            end
        end
    end

    assign pulse_c = ~i_clear & (edge_c | (cnt_q != '0));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_q <= 1'b0;
            cnt_q  <= '0;
            evt_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            prev_q <= i_in;
            cnt_q  <= cnt_d;
            evt_q  <= evt_d;
            ovf_q  <= ovf_d;
        end
    end

endmodule

// File: rtl/edge_pulser.sv
// Multi-channel edge pulser: CH independent channels plus optional one-cycle output staging.
module edge_pulser
    import pulser_pkg::*;
#(
    parameter int unsigned CH        = 4,
    parameter int unsigned PULSE_LEN = 1,
    parameter int unsigned REG_OUT   = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [CH-1:0]        i_in,
    input  logic [MODE_W*CH-1:0] i_mode,
    input  logic [CH-1:0]        i_clear,
    input  logic [CH-1:0]        i_ack,
    output logic [CH-1:0]        o_pulse,
    output logic [CH-1:0]        o_event,
    output logic [CH-1:0]        o_ovf,
    output logic                 o_any
);

    logic [CH-1:0] pulse_c;
    logic [CH-1:0] evt;
    logic [CH-1:0] ovf;
    logic          any_c;

    for (genvar c = 0; c < int'(CH); c++) begin : g_ch
        edge_pulser_ch #(
            .PULSE_LEN (PULSE_LEN)
        ) u_ch (
            .i_clk   (i_clk),
            .i_rst   (i_rst),
            .i_in    (i_in[c]),
            .i_mode  (i_mode[MODE_W*c +: MODE_W]),
            .i_clear (i_clear[c]),
            .i_ack   (i_ack[c]),
            .pulse_c (pulse_c[c]),
            .evt_q   (evt[c]),
            .ovf_q   (ovf[c])
        );
    end

    assign any_c = |evt;

    if (REG_OUT != 0) begin : g_reg
        logic [CH-1:0] pulse_q;
        logic [CH-1:0] evt_q;
        logic [CH-1:0] ovf_q;
        logic          any_q;

        // Uniform one-cycle delay on every output.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                pulse_q <= '0;
                evt_q   <= '0;
                ovf_q   <= '0;
                any_q   <= 1'b0;
            end else begin
                pulse_q <= pulse_c;
                evt_q   <= evt;
                ovf_q   <= ovf;
                any_q   <= any_c;
            end
        end

        assign o_pulse = pulse_q;
        assign o_event = evt_q;
        assign o_ovf   = ovf_q;
        assign o_any   = any_q;
    end else begin : g_comb
        assign o_pulse = pulse_c;
        assign o_event = evt;
        assign o_ovf   = ovf;
        assign o_any   = any_c;
    end

endmodule

// File: tb/tb_edge_pulser.sv
// Random-stimulus bench: three edge_pulser variants share inputs and are scored against a timestamp model.
module tb_edge_pulser;

    localparam int unsigned CH    = 4;
    localparam int unsigned LEN_A = 4;
    localparam int unsigned LEN_C = 1;
    localparam int unsigned N_CYC = 3000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CH-1:0]   in_v = '0;
    logic [2*CH-1:0] mode_v = '0;
    logic [CH-1:0]   clr_v = '0;
    logic [CH-1:0]   ack_v = '0;

    logic [CH-1:0] a_pulse, a_evt, a_ovf;
    logic          a_any;
    logic [CH-1:0] b_pulse, b_evt, b_ovf;
    logic          b_any;
    logic [CH-1:0] c_pulse, c_evt, c_ovf;
    logic          c_any;

    always #5 clk = ~clk;

    edge_pulser #(.CH(CH), .PULSE_LEN(LEN_A), .REG_OUT(0)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_in(in_v), .i_mode(mode_v), .i_clear(clr_v), .i_ack(ack_v),
        .o_pulse(a_pulse), .o_event(a_evt), .o_ovf(a_ovf), .o_any(a_any)
    );
    edge_pulser #(.CH(CH), .PULSE_LEN(LEN_A), .REG_OUT(1)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_in(in_v), .i_mode(mode_v), .i_clear(clr_v), .i_ack(ack_v),
        .o_pulse(b_pulse), .o_event(b_evt), .o_ovf(b_ovf), .o_any(b_any)
    );
    edge_pulser #(.CH(CH), .PULSE_LEN(LEN_C), .REG_OUT(0)) dut_c (
        .i_clk(clk), .i_rst(rst), .i_in(in_v), .i_mode(mode_v), .i_clear(clr_v), .i_ack(ack_v),
        .o_pulse(c_pulse), .o_event(c_evt), .o_ovf(c_ovf), .o_any(c_any)
    );

    typedef struct packed {
        logic [CH-1:0] pulse;
        logic [CH-1:0] evt;
        logic [CH-1:0] ovf;
        logic          any;
    } obs_t;

    typedef struct {
        obs_t a;
        obs_t b;
        obs_t c;
        int   cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: last edge timestamp per channel plus sticky flags.
    logic [CH-1:0] m_prev = '0;
    logic [CH-1:0] m_evt  = '0;
    logic [CH-1:0] m_ovf  = '0;
    int            m_last[CH];
    obs_t          last_a = '0;
    logic          last_rst = 1'b1;
    int            cyc = 0;

    function automatic void check(input string nm, input logic [CH-1:0] got,
                                  input logic [CH-1:0] exp, input int at);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%b expected=%b", nm, at, got, exp);
        end
    endfunction

    task automatic drive_cycle(input logic r, input logic [CH-1:0] vin,
                               input logic [2*CH-1:0] vmode, input logic [CH-1:0] vclr,
                               input logic [CH-1:0] vack);
        exp_t          e;
        obs_t          oa;
        obs_t          oc;
        logic [CH-1:0] edg;
        logic [1:0]    md;
        @(posedge clk);
        #1;
        rst    = r;
        in_v   = vin;
        mode_v = vmode;
        clr_v  = vclr;
        ack_v  = vack;
        oa = '0;
        oc = '0;
        for (int c = 0; c < int'(CH); c++) begin
            md = vmode[2*c +: 2];
            case (md)
                2'b01:   edg[c] = vin[c] && !m_prev[c];
                2'b10:   edg[c] = !vin[c] && m_prev[c];
                2'b11:   edg[c] = vin[c] != m_prev[c];
                default: edg[c] = 1'b0;
            endcase
            if (vclr[c]) edg[c] = 1'b0;
            oa.pulse[c] = !vclr[c] && (edg[c] || (m_last[c] >= 0 && cyc - m_last[c] < int'(LEN_A)));
            oc.pulse[c] = !vclr[c] && (edg[c] || (m_last[c] >= 0 && cyc - m_last[c] < int'(LEN_C)));
        end
        oa.evt = m_evt;
        oa.ovf = m_ovf;
        oa.any = |m_evt;
        oc.evt = m_evt;
        oc.ovf = m_ovf;
        oc.any = |m_evt;
        e.a   = oa;
        e.c   = oc;
        e.b   = last_rst ? '0 : last_a;
        e.cyc = cyc;
        sb_q.push_back(e);
        // Advance model state as of the coming clock edge.
        for (int c = 0; c < int'(CH); c++) begin
            if (r) begin
                m_prev[c] = 1'b0;
                m_last[c] = -1;
                m_evt[c]  = 1'b0;
                m_ovf[c]  = 1'b0;
            end else begin
                m_prev[c] = vin[c];
                if (vclr[c]) begin
                    m_last[c] = -1;
                    m_evt[c]  = 1'b0;
                    m_ovf[c]  = 1'b0;
                end else begin
                    if (edg[c]) m_last[c] = cyc;
                    if (edg[c] && m_evt[c] && !vack[c]) m_ovf[c] = 1'b1;
                    else if (vack[c])                   m_ovf[c] = 1'b0;
                    if (edg[c])       m_evt[c] = 1'b1;
                    else if (vack[c]) m_evt[c] = 1'b0;
                end
            end
        end
        last_a   = oa;
        last_rst = r;
        cyc++;
    endtask

    // Monitor: mid-cycle sampling against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("a_pulse", a_pulse, e.a.pulse, e.cyc);
            check("a_event", a_evt, e.a.evt, e.cyc);
            check("a_ovf", a_ovf, e.a.ovf, e.cyc);
            check("a_any", {{(CH-1){1'b0}}, a_any}, {{(CH-1){1'b0}}, e.a.any}, e.cyc);
            check("b_pulse", b_pulse, e.b.pulse, e.cyc);
            check("b_event", b_evt, e.b.evt, e.cyc);
            check("b_ovf", b_ovf, e.b.ovf, e.cyc);
            check("b_any", {{(CH-1){1'b0}}, b_any}, {{(CH-1){1'b0}}, e.b.any}, e.cyc);
            check("c_pulse", c_pulse, e.c.pulse, e.cyc);
            check("c_event", c_evt, e.c.evt, e.cyc);
            check("c_ovf", c_ovf, e.c.ovf, e.cyc);
            check("c_any", {{(CH-1){1'b0}}, c_any}, {{(CH-1){1'b0}}, e.c.any}, e.cyc);
        end
    end

    initial begin
        logic [CH-1:0]   vin;
        logic [2*CH-1:0] vmode;
        logic [CH-1:0]   vclr;
        logic [CH-1:0]   vack;
        logic [CH-1:0]   tgl;
        logic            r;
        int unsigned     tgl_div;
        for (int c = 0; c < int'(CH); c++) m_last[c] = -1;
        vin   = '0;
        vmode = 8'b11_10_01_11;
        // Reset with live inputs, including levels high across release.
        for (int i = 0; i < 4; i++) begin
            vin = CH'($urandom);
            drive_cycle(1'b1, (i == 3) ? '1 : vin, vmode, '0, '0);
        end
        vin = '1;
        for (int i = 0; i < int'(N_CYC); i++) begin
            tgl_div = ((i / 250) % 2 == 0) ? 2 : 8;
            for (int c = 0; c < int'(CH); c++) begin
                tgl[c]  = ($urandom_range(tgl_div - 1) == 0);
                vclr[c] = ($urandom_range(15) == 0);
                vack[c] = ($urandom_range(5) == 0);
            end
            vin = vin ^ tgl;
            if ($urandom_range(31) == 0) vmode = (2*CH)'($urandom);
            r = 1'b0;
            if (i % 400 >= 394) vin = '1;
            if (i % 400 >= 396) r = 1'b1;
            if ($urandom_range(299) == 0) r = 1'b1;
            drive_cycle(r, vin, vmode, vclr, vack);
        end
        drive_cycle(1'b0, vin, vmode, '0, '0);
        repeat (3) @(posedge clk);
        n_vec++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/edge_pulser.md
EDGE_PULSER -- requirements
Module: edge_pulser

Interface
REQ-001 SHALL have parameter CH, default 4, meaning number of independent channels (1..32).
REQ-002 SHALL have parameter PULSE_LEN, default 1, meaning output pulse length in cycles (1..255).
REQ-003 SHALL have parameter REG_OUT, default 0, meaning 0 for same-cycle outputs and 1 for all outputs delayed one cycle through a register.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port i_rst, input, 1, reset that is synchronous and active-high.
REQ-006 SHALL have port i_in, input, CH, per-channel level inputs, synchronous to i_clk.
REQ-007 SHALL have port i_mode, input, 2*CH, per-channel edge select: 00 off, 01 rise, 10 fall, 11 both.
REQ-008 SHALL have port i_clear, input, CH, per-channel abort/suppress.
REQ-009 SHALL have port i_ack, input, CH, per-channel event acknowledge.
REQ-010 SHALL have port o_pulse, output, CH, stretched edge pulses.
REQ-011 SHALL have port o_event, output, CH, sticky pending-event flags.
REQ-012 SHALL have port o_ovf, output, CH, sticky overflow flags.
REQ-013 SHALL have port o_any, output, 1, OR of o_event.

Function
REQ-014 SHALL keep, per channel, prev register = i_in of the previous cycle.
REQ-015 SHALL define edge[c] = mode-selected (i_in & ~prev) / (~i_in & prev) / XOR, forced 0 when mode 00 or i_clear[c]=1.
REQ-016 SHALL, when REG_OUT=0, drive o_pulse[c] = edge[c] | (cnt[c]!=0), so the first pulse cycle equals the edge cycle (zero latency).
REQ-017 SHALL load cnt[c] with PULSE_LEN-1 on edge[c]; otherwise decrement if nonzero; width clog2(PULSE_LEN+1), saturating at 0, never wrapping.
REQ-018 SHALL restart the stretch on an edge during an active stretch: pulse stays high, PULSE_LEN cycles from the new edge, no gap.
REQ-019 SHALL, with PULSE_LEN=1, make o_pulse identical to edge (single-cycle pulse per edge).
REQ-020 SHALL set o_event[c] the cycle after edge[c]; i_ack[c] clears it next cycle; simultaneous edge and ack leaves it set (set wins).
REQ-021 SHALL set o_ovf[c] when edge[c]=1 while o_event[c]=1 and i_ack[c]=0; i_ack[c] clears o_ovf[c]; set wins on collision.
REQ-022 SHALL, on i_clear[c], clear cnt[c], o_event[c] and o_ovf[c] next cycle; prev still samples i_in, so a level held across clear produces no edge on release.
REQ-023 SHALL let i_clear take priority over edge and i_ack; a mode change takes effect immediately, with no edge generated by the mode change itself.
REQ-024 SHALL, when REG_OUT=1, delay o_pulse, o_event, o_ovf and o_any by exactly one cycle, with no other behavioural difference.
REQ-025 SHALL keep channels fully independent: no cross-channel interaction except o_any.

Reset
REQ-026 SHALL, when i_rst=1 at a clock edge, set prev, cnt, o_event, o_ovf and output registers to 0.
REQ-027 SHALL leave o_pulse combinational from i_in during reset when REG_OUT=0, so a high i_in while i_rst=1 may show a pulse.
REQ-028 SHALL treat i_in=1 on the first cycle after reset release as a rising edge, since prev=0.
REQ-029 SHALL abort an active stretch on reset mid-pulse; o_pulse is 0 the cycle after reset, unless a new edge occurs.

Structure
REQ-030 SHALL place mode encodings (MODE_OFF/RISE/FALL/BOTH) and the counter-width function in shared package pulser_pkg.
REQ-031 SHALL implement one channel as sub-module edge_pulser_ch, generated CH times; top adds o_any and REG_OUT staging.

Verification
REQ-032 SHALL cover: CH=4, PULSE_LEN=1, mode 01, i_in[0] 0->1 at cycle 10 -> o_pulse[0]=1 only at cycle 10; o_event[0]=1 from 11 until ack.
REQ-033 SHALL cover: PULSE_LEN=4, mode 11, toggle at cycle 5 and again at 7 -> o_pulse high cycles 5..10 continuous.
REQ-034 SHALL cover: edges at cycles 3 and 8 with no ack -> o_ovf=1 from 9; ack at 8 instead -> o_event stays 1, o_ovf=0.
REQ-035 SHALL cover: i_clear at cycle 6 during a 4-cycle stretch and a rise at 6 -> o_pulse low from 6, o_event=0 at 7, no pulse after clear released with input held high.
REQ-036 SHALL cover: i_in held 1 through i_rst, release at cycle 20 -> pulse at 20 (mode 01); mode 10 -> none; REG_OUT=1 -> all at +1 cycle.
